// File: rtl/traffic_light_monitor.sv
// Passive safety checker for the Traffic_Top lamp bus {A_G,A_Y,A_R,B_G,B_Y,B_R}.
// Flags invalid heads, conflicts, illegal sequencing and short yellow dwell as sticky bits.
module traffic_light_monitor #(
  parameter int unsigned YELLOW_MIN_CYCLES = 500000000,
  parameter int unsigned CNT_W             = 32,
  parameter int unsigned PHASE_W           = 16
) (
  input  logic               clk_100MHz,
  input  logic               reset_n,
  input  logic [5:0]         led,
  input  logic               clear,
  output logic [3:0]         err_flags,
  output logic               err_any,
  output logic               fault_pulse,
  output logic [PHASE_W-1:0] phase_count
);

  typedef enum logic [1:0] {
    HEAD_INVALID,
    HEAD_GREEN,
    HEAD_YELLOW,
    HEAD_RED
  } head_e;

  localparam logic [CNT_W-1:0] YellowMin = CNT_W'(YELLOW_MIN_CYCLES);

  function automatic head_e decodeHead(input logic [2:0] gyr);
    head_e s;
    case (gyr)
      3'b100:  s = HEAD_GREEN;
      3'b010:  s = HEAD_YELLOW;
      3'b001:  s = HEAD_RED;
      default: s = HEAD_INVALID;
    endcase
    return s;
  endfunction

  function automatic logic stepLegal(input head_e p, input head_e c);
    return (p == c) ||
           (p == HEAD_GREEN  && c == HEAD_YELLOW) ||
           (p == HEAD_YELLOW && c == HEAD_RED) ||
           (p == HEAD_RED    && c == HEAD_GREEN);
  endfunction

  logic [5:0]         led_q;
  logic [5:0]         led_p;
  logic               loaded_q;
  logic               prevValid_q;
  logic [CNT_W-1:0]   dwell_q [2];
  logic [CNT_W-1:0]   dwell_d [2];
  logic [3:0]         errFlags_q;
  logic [3:0]         errFlags_d;
  logic               faultPulse_q;
  logic [PHASE_W-1:0] phaseCount_q;
  logic [PHASE_W-1:0] phaseCount_d;
  head_e              curHead [2];
  head_e              prvHead [2];
  logic [3:0]         fire;

  // Index 0 is street A, index 1 is street B. The reset value of led_q is not a
  // lamp sample, so the per-cycle checks wait until the first real load.
  always_comb begin
    curHead[0]   = decodeHead(led_q[5:3]);
    curHead[1]   = decodeHead(led_q[2:0]);
    prvHead[0]   = decodeHead(led_p[5:3]);
    prvHead[1]   = decodeHead(led_p[2:0]);
    fire         = '0;
    phaseCount_d = phaseCount_q;

    if (loaded_q) begin
      for (int h = 0; h < 2; h++) begin
        if (curHead[h] == HEAD_INVALID) fire[0] = 1'b1;
      end
      if (curHead[0] != HEAD_RED && curHead[1] != HEAD_RED) fire[1] = 1'b1;
    end

    for (int h = 0; h < 2; h++) begin
      dwell_d[h] = '0;
      if (curHead[h] == HEAD_YELLOW) begin
        if (prvHead[h] != HEAD_YELLOW) dwell_d[h] = CNT_W'(1);
        else if (dwell_q[h] < YellowMin) dwell_d[h] = dwell_q[h] + CNT_W'(1);
        else dwell_d[h] = dwell_q[h];
      end

      if (prevValid_q && curHead[h] != HEAD_INVALID && prvHead[h] != HEAD_INVALID) begin
        if (!stepLegal(prvHead[h], curHead[h])) fire[2] = 1'b1;
        if (prvHead[h] == HEAD_YELLOW && curHead[h] == HEAD_RED && dwell_q[h] < YellowMin)
          fire[3] = 1'b1;
      end
    end

    if (prevValid_q && prvHead[0] == HEAD_RED && curHead[0] == HEAD_GREEN)
      phaseCount_d = phaseCount_q + PHASE_W'(1);

    // A check firing in the same cycle as clear still lands in the flags.
    errFlags_d = (clear ? 4'b0000 : errFlags_q) | fire;
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      led_q        <= '0;
      led_p        <= '0;
      loaded_q     <= 1'b0;
      prevValid_q  <= 1'b0;
      for (int h = 0; h < 2; h++) dwell_q[h] <= '0;
      errFlags_q   <= '0;
      faultPulse_q <= 1'b0;
      phaseCount_q <= '0;
    end else begin
      led_q        <= led;
      led_p        <= led_q;
      loaded_q     <= 1'b1;
      prevValid_q  <= loaded_q;
      for (int h = 0; h < 2; h++) dwell_q[h] <= dwell_d[h];
      errFlags_q   <= errFlags_d;
      faultPulse_q <= |fire;
      phaseCount_q <= phaseCount_d;
    end
  end

  assign err_flags   = errFlags_q;
  assign err_any     = |errFlags_q;
  assign fault_pulse = faultPulse_q;
  assign phase_count = phaseCount_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Testbench for traffic_light_monitor: directed vector table, hand sequences for reset,
// then randomized lamp traffic scored against a sample-history reference model.
module tb_traffic_light_monitor;

  localparam int YMIN = 4;
  localparam int PW   = 4;

  logic          clk = 1'b0;
  logic          rstN;
  logic [5:0]    ledIn;
  logic          clearIn;
  logic [3:0]    errFlags;
  logic          errAny;
  logic          faultPulse;
  logic [PW-1:0] phaseCount;

  traffic_light_monitor #(
    .YELLOW_MIN_CYCLES(YMIN),
    .CNT_W(32),
    .PHASE_W(PW)
  ) dut (
    .clk_100MHz (clk),
    .reset_n    (rstN),
    .led        (ledIn),
    .clear      (clearIn),
    .err_flags  (errFlags),
    .err_any    (errAny),
    .fault_pulse(faultPulse),
    .phase_count(phaseCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]    led;
    logic          clr;
    int            reps;
    logic [3:0]    flags;
    logic          pulse;
    logic [PW-1:0] phase;
  } vec_t;

  vec_t          vecs[$];
  logic [5:0]    samp[$];
  logic [3:0]    mFlags;
  logic          mPulse;
  logic [PW-1:0] mPhase;
  int            errors = 0;
  int            checks = 0;
  logic [5:0]    pats [6] = '{6'b100001, 6'b010001, 6'b001001, 6'b001100, 6'b001010, 6'b001001};

  // Head decode as 0=green, 1=yellow, 2=red, 3=invalid; legal moves advance by one mod 3.
  function automatic int headOf(input logic [5:0] v, input int h);
    logic [2:0] b;
    b = (h == 0) ? v[5:3] : v[2:0];
    if ($countones(b) != 1) return 3;
    if (b[2]) return 0;
    if (b[1]) return 1;
    return 2;
  endfunction

  task automatic modelReset();
    samp.delete();
    mFlags = 4'b0000;
    mPulse = 1'b0;
    mPhase = '0;
  endtask

  // Each edge appends the sample just captured; the checks reported at this edge
  // judge the sample captured one edge earlier against the one before that.
  task automatic modelEdge(input logic [5:0] v, input logic clr);
    logic [3:0] fire;
    logic [5:0] cur;
    logic [5:0] prv;
    int n, c, p, run;
    fire = 4'b0000;
    samp.push_back(v);
    n = samp.size();
    if (n >= 2) begin
      cur = samp[n-2];
      for (int h = 0; h < 2; h++) if (headOf(cur, h) == 3) fire[0] = 1'b1;
      if (headOf(cur, 0) != 2 && headOf(cur, 1) != 2) fire[1] = 1'b1;
      if (n >= 3) begin
        prv = samp[n-3];
        for (int h = 0; h < 2; h++) begin
          c = headOf(cur, h);
          p = headOf(prv, h);
          if (c != 3 && p != 3) begin
            if (c != p && c != (p + 1) % 3) fire[2] = 1'b1;
            if (p == 1 && c == 2) begin
              run = 0;
              for (int i = n - 3; i >= 0; i--) begin
                if (headOf(samp[i], h) != 1) break;
                run++;
              end
              if (run < YMIN) fire[3] = 1'b1;
            end
            if (h == 0 && p == 2 && c == 0) mPhase = mPhase + 1'b1;
          end
        end
      end
    end
    mFlags = (clr ? 4'b0000 : mFlags) | fire;
    mPulse = |fire;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] f, input logic p, input logic [PW-1:0] ph);
    checks++;
    if (errFlags !== f || faultPulse !== p || phaseCount !== ph || errAny !== (|f)) begin
      errors++;
      $display("[TB] FAIL %s t=%0t: flags=%b pulse=%b phase=%0d any=%b, expected flags=%b pulse=%b phase=%0d any=%b",
               name, $time, errFlags, faultPulse, phaseCount, errAny, f, p, ph, |f);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] v, input logic clr);
    ledIn   = v;
    clearIn = clr;
    @(posedge clk);
    modelEdge(v, clr);
    #1;
    checkOutput("model", mFlags, mPulse, mPhase);
  endtask

  task automatic addVec(input logic [5:0] l, input logic c, input int r, input logic [3:0] f,
                        input logic p, input logic [PW-1:0] ph);
    vec_t v;
    v.led = l; v.clr = c; v.reps = r; v.flags = f; v.pulse = p; v.phase = ph;
    vecs.push_back(v);
  endtask

  initial begin
    int idx, remaining;
    logic [5:0] v;

    // Legal full cycle, then conflict, short yellow, bad jump, invalid head, clear, all-flags.
    addVec(6'b100001, 0, 10, 4'b0000, 0, 0);
    addVec(6'b010001, 0,  5, 4'b0000, 0, 0);
    addVec(6'b001001, 0,  1, 4'b0000, 0, 0);
    addVec(6'b001100, 0, 10, 4'b0000, 0, 0);
    addVec(6'b001010, 0,  5, 4'b0000, 0, 0);
    addVec(6'b001001, 0,  1, 4'b0000, 0, 0);
    addVec(6'b100001, 0,  2, 4'b0000, 0, 1);
    addVec(6'b100100, 0,  1, 4'b0000, 0, 1);
    addVec(6'b100001, 0,  1, 4'b0010, 1, 1);
    addVec(6'b100001, 0,  1, 4'b0110, 1, 1);
    addVec(6'b100001, 0,  1, 4'b0110, 0, 1);
    addVec(6'b100001, 1,  1, 4'b0000, 0, 1);
    addVec(6'b010001, 0,  2, 4'b0000, 0, 1);
    addVec(6'b001001, 0,  1, 4'b0000, 0, 1);
    addVec(6'b001001, 0,  1, 4'b1000, 1, 1);
    addVec(6'b001001, 0,  1, 4'b1000, 0, 1);
    addVec(6'b100001, 1,  1, 4'b0000, 0, 1);
    addVec(6'b100001, 0,  1, 4'b0000, 0, 2);
    addVec(6'b010001, 0,  4, 4'b0000, 0, 2);
    addVec(6'b001001, 0,  2, 4'b0000, 0, 2);
    addVec(6'b100001, 0,  2, 4'b0000, 0, 3);
    addVec(6'b001001, 0,  1, 4'b0000, 0, 3);
    addVec(6'b001001, 0,  1, 4'b0100, 1, 3);
    addVec(6'b000001, 0,  1, 4'b0100, 0, 3);
    addVec(6'b000001, 0,  1, 4'b0101, 1, 3);
    addVec(6'b001001, 0,  1, 4'b0101, 1, 3);
    addVec(6'b001001, 1,  1, 4'b0000, 0, 3);
    addVec(6'b110001, 1,  1, 4'b0000, 0, 3);
    addVec(6'b110001, 1,  1, 4'b0001, 1, 3);
    addVec(6'b010001, 0,  1, 4'b0001, 1, 3);
    addVec(6'b010001, 0,  1, 4'b0001, 0, 3);
    addVec(6'b001001, 0,  1, 4'b0001, 0, 3);
    addVec(6'b010010, 0,  1, 4'b1001, 1, 3);
    addVec(6'b010010, 0,  1, 4'b1111, 1, 3);

    rstN    = 1'b0;
    ledIn   = 6'b000000;
    clearIn = 1'b0;
    modelReset();
    #22;
    checkOutput("resetHeld", 4'b0000, 1'b0, '0);
    #1 rstN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < vecs[i].reps; r++) applyStimulus(vecs[i].led, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].flags, vecs[i].pulse, vecs[i].phase);
    end

    // Asynchronous reset in mid-cycle must zero every output without waiting for an edge.
    #3 rstN = 1'b0;
    #1 checkOutput("resetAsync", 4'b0000, 1'b0, '0);
    modelReset();
    @(posedge clk);
    #1 checkOutput("resetHold", 4'b0000, 1'b0, '0);
    #2 rstN = 1'b1;
    for (int r = 0; r < 3; r++) begin
      applyStimulus(6'b001100, 1'b0);
      checkOutput($sformatf("postReset%0d", r), 4'b0000, 1'b0, '0);
    end

    idx = 0;
    remaining = $urandom_range(1, 6);
    for (int s = 0; s < 2500; s++) begin
      if ($urandom_range(0, 19) == 0) v = 6'($urandom_range(0, 63));
      else v = pats[idx];
      remaining--;
      if (remaining == 0) begin
        idx = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 5) : (idx + 1) % 6;
        remaining = $urandom_range(1, 6);
      end
      applyStimulus(v, $urandom_range(0, 14) == 0);
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
